// File: rtl/sccb_writer.sv
// SCCB three-phase write master: shifts DEV_ID, register address and data out on scl/sda.
// Define SCCB_WRITER_QUEUE_EN to add a one-deep request buffer behind the active transfer.
module sccb_writer #(
  parameter logic [7:0]  DEV_ID  = 8'h42,
  parameter int unsigned QTR_DIV = 63
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  output logic       busy,
  output logic       done,
  output logic       scl,
  output logic       sda
);

  // state   | meaning
  // S_IDLE  | bus released (scl=1, sda=1), waiting for a request
  // S_START | 2 quarters: sda falls with scl high, then scl falls
  // S_BIT   | 27 bits x 4 quarters, scl pattern 0,1,1,0 per bit
  // S_STOP  | 3 quarters: scl rises with sda low, then sda rises

  localparam int TW = $clog2(QTR_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(QTR_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [1:0]    qtr, qtr_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [26:0]   shreg, shreg_nx;
  logic          scl_nx, sda_nx, busy_nx, done_nx;
  logic          wrap;
  logic          q_valid, q_valid_nx;
  logic [15:0]   q_req;

  function automatic logic [26:0] frame(input logic [15:0] req);
    return {DEV_ID, 1'b1, req[15:8], 1'b1, req[7:0], 1'b1};
  endfunction

  assign wrap = (tick == TICK_LAST);

`ifdef SCCB_WRITER_QUEUE_EN
  logic q_pop, q_push;

  // The buffer only drains in the done cycle, the one IDLE cycle where it can be full.
  assign q_pop      = (state == S_IDLE) && q_valid;
  assign q_push     = start && busy && !q_valid;
  assign q_valid_nx = q_push || (q_valid && !q_pop);

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_req   <= '0;
    end else begin
      q_valid <= q_valid_nx;
      if (q_push) q_req <= {i_addr, i_data};
    end
  end
`else
  assign q_valid    = 1'b0;
  assign q_valid_nx = 1'b0;
  assign q_req      = '0;
`endif

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tick    <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      scl     <= 1'b1;
      sda     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      qtr     <= qtr_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      scl     <= scl_nx;
      sda     <= sda_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tick_nx    = tick;
    qtr_nx     = qtr;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    done_nx    = 1'b0;
    if (state != S_IDLE) tick_nx = wrap ? '0 : tick + 1'b1;
    case (state)
      S_IDLE: begin
        if (q_valid || start) begin
          state_nx   = S_START;
          tick_nx    = '0;
          qtr_nx     = '0;
          bit_cnt_nx = '0;
          shreg_nx   = q_valid ? frame(q_req) : frame({i_addr, i_data});
        end
      end
      S_START: begin
        if (wrap) begin
          if (qtr == 2'd1) begin
            state_nx   = S_BIT;
            qtr_nx     = '0;
            bit_cnt_nx = '0;
          end else begin
            qtr_nx = qtr + 2'd1;
          end
        end
      end
      S_BIT: begin
        if (wrap) begin
          qtr_nx = qtr + 2'd1;
          if (qtr == 2'd3) begin
            shreg_nx   = {shreg[25:0], 1'b1};
            bit_cnt_nx = bit_cnt + 5'd1;
            if (bit_cnt == 5'd26) state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (wrap) begin
          if (qtr == 2'd2) begin
            state_nx = S_IDLE;
            qtr_nx   = '0;
            done_nx  = 1'b1;
          end else begin
            qtr_nx = qtr + 2'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decoded from the next state so scl/sda leave as clean flops.
  always_comb begin
    scl_nx = 1'b1;
    sda_nx = 1'b1;
    case (state_nx)
      S_START: begin
        scl_nx = (qtr_nx == 2'd0);
        sda_nx = 1'b0;
      end
      S_BIT: begin
        scl_nx = (qtr_nx == 2'd1) || (qtr_nx == 2'd2);
        sda_nx = shreg_nx[26];
      end
      S_STOP: begin
        scl_nx = (qtr_nx != 2'd0);
        sda_nx = (qtr_nx == 2'd2);
      end
      default: begin
        scl_nx = 1'b1;
        sda_nx = 1'b1;
      end
    endcase
    busy_nx = (state_nx != S_IDLE) || q_valid_nx;
  end

endmodule
